// File: rtl/mdio_pkg.sv
// Purpose: shared types and constants for the Clause-22 MDIO target.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mdio_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDATA,
    SKIP
  } mdio_state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int ST_LEN      = 2;
  localparam int OP_LEN      = 2;
  localparam int PHYAD_LEN   = 5;
  localparam int REGAD_LEN   = 5;
  localparam int TA_LEN      = 2;
  localparam int MDIO_DATA_W = 16;

  // Edges between e(14) and e(31) inclusive that an unselected frame still occupies.
  localparam int SKIP_LEN = TA_LEN + MDIO_DATA_W;

endpackage

// File: rtl/mdio_preamble_det.sv
// Purpose: saturating count of consecutive preamble 1s; flags the ST 0 bit once enough were seen.
// Latency: start is combinational on the edge that samples b0; the count is registered.
// Backpressure: none; counting only runs while enable (FSM idle) is high.
module mdio_preamble_det
  import mdio_pkg::*;
#(
  parameter int PRE_LEN = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic mdio_oe,
  input  logic mdio_out,
  output logic start
);

  localparam int CW = $clog2(PRE_LEN + 1);

  logic [CW-1:0] count;
  logic          full;

  assign full  = (count == CW'(PRE_LEN));
  assign start = enable & mdio_oe & ~mdio_out & full;

  // Count 1s while idle; any gap (released bus or early 0) and any active frame restart from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (mdio_oe && mdio_out) begin
      if (!full) count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/mdio_peripheral_px.sv
// Purpose: Clause-22 MDIO target; decodes station frames into register-bank strobes and serial read data.
// Latency: ADDR/RD_STB registered at e(13), read data driven e(14)..e(31), WR_STB/WR_DATA/MDIO_DONE at e(31).
// Backpressure: none; MDIO is free-running, so malformed or aborted frames pulse MDIO_ERR and are dropped.
module mdio_peripheral_px
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         PRE_LEN  = 32,
  parameter bit         BCAST_EN = 1'b1,
  parameter bit         CHECK_TA = 1'b1,
  parameter int         NUM_REGS = 32
) (
  input  logic        MDC,
  input  logic        RESET,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  input  logic [15:0] RD_DATA,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_STB,
  output logic        MDIO_IN,
  output logic        MDIO_IN_EN,
  output logic        MDIO_DONE,
  output logic        MDIO_ERR
);

  mdio_state_t            state;
  logic [4:0]             cnt;
  logic [1:0]             op;
  logic [4:0]             phyad;
  logic [4:0]             regad;
  logic                   ta_hi;
  logic                   in_rng;
  logic [MDIO_DATA_W-1:0] sh;

  logic       start;
  logic [4:0] regad_next;
  logic       rng_next;
  logic       sel;

  mdio_preamble_det #(.PRE_LEN(PRE_LEN)) u_pre (
    .clk      (MDC),
    .reset    (RESET),
    .enable   (state == IDLE),
    .mdio_oe  (MDIO_OE),
    .mdio_out (MDIO_OUT),
    .start    (start)
  );

  assign regad_next = {regad[3:0], MDIO_OUT};
  assign rng_next   = (32'(regad_next) < 32'(NUM_REGS));
  // Broadcast address only ever selects writes; a broadcast read would have every PHY driving the bus.
  assign sel = (phyad == PHY_ADDR) || (BCAST_EN && (phyad == 5'd0) && (op == OP_WRITE));

  // Frame decoder: one bit per MDC edge, strobes default low so every pulse is one cycle wide.
  always_ff @(posedge MDC) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= '0;
      phyad      <= '0;
      regad      <= '0;
      ta_hi      <= 1'b0;
      in_rng     <= 1'b0;
      sh         <= '0;
      ADDR       <= '0;
      WR_DATA    <= '0;
      WR_STB     <= 1'b0;
      RD_STB     <= 1'b0;
      MDIO_IN    <= 1'b0;
      MDIO_IN_EN <= 1'b0;
      MDIO_DONE  <= 1'b0;
      MDIO_ERR   <= 1'b0;
    end else begin
      WR_STB    <= 1'b0;
      RD_STB    <= 1'b0;
      MDIO_DONE <= 1'b0;
      MDIO_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= ST;
        end
        ST: begin
          if (!MDIO_OE || !MDIO_OUT) begin
            MDIO_ERR <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= OP;
            cnt   <= '0;
          end
        end
        OP: begin
          if (!MDIO_OE) begin
            MDIO_ERR <= 1'b1;
            state    <= IDLE;
          end else if (cnt == 5'd0) begin
            op[1] <= MDIO_OUT;
            cnt   <= 5'd1;
          end else if (({op[1], MDIO_OUT} == OP_READ) || ({op[1], MDIO_OUT} == OP_WRITE)) begin
            op[0] <= MDIO_OUT;
            state <= PHYAD;
            cnt   <= '0;
          end else begin
            MDIO_ERR <= 1'b1;
            state    <= IDLE;
          end
        end
        PHYAD: begin
          if (!MDIO_OE) begin
            MDIO_ERR <= 1'b1;
            state    <= IDLE;
          end else begin
            phyad <= {phyad[3:0], MDIO_OUT};
            if (cnt == 5'(PHYAD_LEN - 1)) begin
              state <= REGAD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        REGAD: begin
          if (!MDIO_OE) begin
            MDIO_ERR <= 1'b1;
            state    <= IDLE;
          end else begin
            regad <= regad_next;
            if (cnt == 5'(REGAD_LEN - 1)) begin
              cnt <= '0;
              if (sel) begin
                ADDR   <= regad_next;
                in_rng <= rng_next;
                RD_STB <= (op == OP_READ) && rng_next;
                state  <= TA;
              end else begin
                state <= SKIP;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        TA: begin
          if (op == OP_READ) begin
            if (cnt == 5'd0) begin
              sh         <= in_rng ? RD_DATA : '0;
              MDIO_IN_EN <= 1'b1;
              MDIO_IN    <= 1'b0;
              cnt        <= 5'd1;
            end else begin
              MDIO_IN <= sh[MDIO_DATA_W-1];
              sh      <= {sh[MDIO_DATA_W-2:0], 1'b0};
              state   <= RDATA;
              cnt     <= '0;
            end
          end else if (!MDIO_OE) begin
            MDIO_ERR <= 1'b1;
            state    <= IDLE;
          end else if (cnt == 5'd0) begin
            ta_hi <= MDIO_OUT;
            cnt   <= 5'd1;
          end else if (CHECK_TA && ({ta_hi, MDIO_OUT} != TA_WRITE)) begin
            MDIO_ERR <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= WDATA;
            cnt   <= '0;
          end
        end
        RDATA: begin
          if (cnt == 5'(MDIO_DATA_W - 1)) begin
            MDIO_IN_EN <= 1'b0;
            MDIO_IN    <= 1'b0;
            MDIO_DONE  <= 1'b1;
            state      <= IDLE;
          end else begin
            MDIO_IN <= sh[MDIO_DATA_W-1];
            sh      <= {sh[MDIO_DATA_W-2:0], 1'b0};
            cnt     <= cnt + 5'd1;
          end
        end
        WDATA: begin
          if (!MDIO_OE) begin
            MDIO_ERR <= 1'b1;
            state    <= IDLE;
          end else if (cnt == 5'(MDIO_DATA_W - 1)) begin
            WR_DATA   <= {sh[MDIO_DATA_W-2:0], MDIO_OUT};
            WR_STB    <= in_rng;
            MDIO_DONE <= 1'b1;
            state     <= IDLE;
          end else begin
            sh  <= {sh[MDIO_DATA_W-2:0], MDIO_OUT};
            cnt <= cnt + 5'd1;
          end
        end
        SKIP: begin
          if (cnt == 5'(SKIP_LEN - 1)) state <= IDLE;
          else cnt <= cnt + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_peripheral_px.sv
// Purpose: randomized and directed frames against two targets (NUM_REGS 32 and 16) with a frame-level model.
// Latency: outputs sampled 1 time unit after each MDC rising edge.
// Backpressure: n/a.
module tb_mdio_peripheral_px;

  logic        MDC;
  logic        RESET;
  logic        MDIO_OE;
  logic        MDIO_OUT;
  logic [15:0] RD_DATA;

  logic [4:0]  addr_a, addr_b;
  logic [15:0] wrd_a, wrd_b;
  logic        wr_a, wr_b, rd_a, rd_b, in_a, in_b, en_a, en_b;
  logic        done_a, done_b, err_a, err_b;

  mdio_peripheral_px u_dut_a (
    .MDC(MDC), .RESET(RESET), .MDIO_OE(MDIO_OE), .MDIO_OUT(MDIO_OUT), .RD_DATA(RD_DATA),
    .ADDR(addr_a), .WR_DATA(wrd_a), .WR_STB(wr_a), .RD_STB(rd_a),
    .MDIO_IN(in_a), .MDIO_IN_EN(en_a), .MDIO_DONE(done_a), .MDIO_ERR(err_a)
  );

  mdio_peripheral_px #(.NUM_REGS(16)) u_dut_b (
    .MDC(MDC), .RESET(RESET), .MDIO_OE(MDIO_OE), .MDIO_OUT(MDIO_OUT), .RD_DATA(RD_DATA),
    .ADDR(addr_b), .WR_DATA(wrd_b), .WR_STB(wr_b), .RD_STB(rd_b),
    .MDIO_IN(in_b), .MDIO_IN_EN(en_b), .MDIO_DONE(done_b), .MDIO_ERR(err_b)
  );

  initial MDC = 1'b0;
  always #5 MDC = ~MDC;

  int checks = 0;
  int errors = 0;

  // Expected per-edge outputs for the current frame, index [dut][frame edge k].
  bit         e_wr[2][32], e_rd[2][32], e_done[2][32], e_err[2][32], e_en[2][32], e_in[2][32];
  logic [4:0]  m_addr[2];
  logic [15:0] m_wrd[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic oe, input logic out, input logic rst);
    @(negedge MDC);
    MDIO_OE  = oe;
    MDIO_OUT = out;
    RESET    = rst;
    @(posedge MDC);
    #1;
  endtask

  task automatic check_edge(input string name, input int k);
    check($sformatf("%s e%0d A{wr,rd,done,err,en,in}", name, k),
          {26'd0, wr_a, rd_a, done_a, err_a, en_a, in_a},
          {26'd0, e_wr[0][k], e_rd[0][k], e_done[0][k], e_err[0][k], e_en[0][k], e_in[0][k]});
    check($sformatf("%s e%0d B{wr,rd,done,err,en,in}", name, k),
          {26'd0, wr_b, rd_b, done_b, err_b, en_b, in_b},
          {26'd0, e_wr[1][k], e_rd[1][k], e_done[1][k], e_err[1][k], e_en[1][k], e_in[1][k]});
  endtask

  task automatic check_quiet(input string name);
    check({name, " quiet A"}, {26'd0, wr_a, rd_a, done_a, err_a, en_a, in_a}, 32'd0);
    check({name, " quiet B"}, {26'd0, wr_b, rd_b, done_b, err_b, en_b, in_b}, 32'd0);
  endtask

  task automatic check_regs(input string name);
    check({name, " A.ADDR"}, {27'd0, addr_a}, {27'd0, m_addr[0]});
    check({name, " A.WR_DATA"}, {16'd0, wrd_a}, {16'd0, m_wrd[0]});
    check({name, " B.ADDR"}, {27'd0, addr_b}, {27'd0, m_addr[1]});
    check({name, " B.WR_DATA"}, {16'd0, wrd_b}, {16'd0, m_wrd[1]});
  endtask

  // Frame-level reference: decides the outcome of the whole frame from its fields, then places events on edges.
  task automatic model(input int pre, input logic b1, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] data,
                       input logic [15:0] rdd, input int drop);
    int          n;
    int          eb;
    bit          sel;
    logic [15:0] dv;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 32 : 16;
      for (int k = 0; k < 32; k++) begin
        e_wr[d][k] = 0; e_rd[d][k] = 0; e_done[d][k] = 0;
        e_err[d][k] = 0; e_en[d][k] = 0; e_in[d][k] = 0;
      end
      sel = (phy == 5'd1) || (phy == 5'd0 && op == 2'b01);
      if (pre >= 32) begin
        if (!b1) e_err[d][1] = 1;
        else if (op != 2'b01 && op != 2'b10) e_err[d][3] = 1;
        else if (sel) begin
          m_addr[d] = rg;
          if (op == 2'b10) begin
            dv = (rg < n) ? rdd : 16'h0000;
            e_rd[d][13] = (rg < n);
            for (int k = 14; k <= 30; k++) e_en[d][k] = 1;
            for (int k = 15; k <= 30; k++) e_in[d][k] = dv[30-k];
            e_done[d][31] = 1;
          end else begin
            eb = -1;
            if (drop == 14 || drop == 15) eb = drop;
            else if (ta != 2'b10) eb = 15;
            else if (drop >= 16) eb = drop;
            if (eb >= 0) e_err[d][eb] = 1;
            else begin
              e_done[d][31] = 1;
              e_wr[d][31]   = (rg < n);
              m_wrd[d]      = data;
            end
          end
        end
      end
    end
  endtask

  task automatic run_frame(input string name, input int pre, input logic b1, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] rg, input logic [1:0] ta,
                           input logic [15:0] data, input logic [15:0] rdd, input int drop);
    logic [31:0] fr;
    logic        oe, out;
    fr = {1'b0, b1, op, phy, rg, ta, data};
    model(pre, b1, op, phy, rg, ta, data, rdd, drop);
    RD_DATA = rdd;
    for (int i = 0; i < pre; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      check_quiet({name, " pre"});
    end
    for (int k = 0; k < 32; k++) begin
      oe  = 1'b1;
      out = fr[31-k];
      if (op == 2'b10 && k >= 14) begin oe = 1'b0; out = 1'b0; end
      if (drop >= 0 && k >= drop) begin oe = 1'b0; out = 1'b0; end
      drive(oe, out, 1'b0);
      check_edge(name, k);
    end
    drive(1'b0, 1'b0, 1'b0);
    check_quiet({name, " post"});
    drive(1'b0, 1'b0, 1'b0);
    check_regs(name);
  endtask

  task automatic reset_mid_read();
    logic [31:0] fr;
    fr = {1'b0, 1'b1, 2'b10, 5'd1, 5'd3, 2'b10, 16'h0000};
    for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b1, fr[31-k], 1'b0);
    drive(1'b1, fr[21], 1'b1);
    m_addr[0] = 5'd0; m_addr[1] = 5'd0; m_wrd[0] = 16'd0; m_wrd[1] = 16'd0;
    check_quiet("rst_mid");
    check_regs("rst_mid");
    drive(1'b0, 1'b0, 1'b0);
    check_quiet("rst_mid after");
  endtask

  initial begin
    int pre, drop;
    logic b1;
    logic [1:0] op, ta;
    logic [4:0] phy;
    RESET = 1'b1; MDIO_OE = 1'b0; MDIO_OUT = 1'b0; RD_DATA = 16'h0;
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    m_addr[0] = 5'd0; m_addr[1] = 5'd0; m_wrd[0] = 16'd0; m_wrd[1] = 16'd0;
    check_quiet("reset");
    check_regs("reset");
    drive(1'b0, 1'b0, 1'b0);

    run_frame("wr_a5c3",   32, 1'b1, 2'b01, 5'd1,  5'd5,  2'b10, 16'hA5C3, 16'h0000, -1);
    run_frame("rd_1234",   32, 1'b1, 2'b10, 5'd1,  5'd3,  2'b10, 16'h0000, 16'h1234, -1);
    run_frame("wr_phy7",   32, 1'b1, 2'b01, 5'd7,  5'd6,  2'b10, 16'h1111, 16'h0000, -1);
    run_frame("wr_bcast",  32, 1'b1, 2'b01, 5'd0,  5'd7,  2'b10, 16'h2222, 16'h0000, -1);
    run_frame("rd_bcast",  32, 1'b1, 2'b10, 5'd0,  5'd8,  2'b10, 16'h0000, 16'hFFFF, -1);
    run_frame("short_pre", 20, 1'b1, 2'b01, 5'd1,  5'd9,  2'b10, 16'h3333, 16'h0000, -1);
    run_frame("op11",      32, 1'b1, 2'b11, 5'd1,  5'd9,  2'b10, 16'h4444, 16'h0000, -1);
    run_frame("oe_drop",   32, 1'b1, 2'b01, 5'd1,  5'd10, 2'b10, 16'h5555, 16'h0000, 20);
    run_frame("wr_ok1",    32, 1'b1, 2'b01, 5'd1,  5'd11, 2'b10, 16'h6666, 16'h0000, -1);
    run_frame("ta11",      32, 1'b1, 2'b01, 5'd1,  5'd12, 2'b11, 16'h7777, 16'h0000, -1);
    run_frame("wr_ok2",    33, 1'b1, 2'b01, 5'd1,  5'd9,  2'b10, 16'h0F0F, 16'h0000, -1);
    reset_mid_read();
    run_frame("rd_after_rst", 32, 1'b1, 2'b10, 5'd1, 5'd3,  2'b10, 16'h0000, 16'hBEEF, -1);
    run_frame("rd_reg31",     32, 1'b1, 2'b10, 5'd1, 5'd31, 2'b10, 16'h0000, 16'hCAFE, -1);
    run_frame("wr_reg20",     32, 1'b1, 2'b01, 5'd1, 5'd20, 2'b10, 16'h9876, 16'h0000, -1);

    for (int t = 0; t < 40; t++) begin
      pre  = ($urandom % 10 == 0) ? int'($urandom_range(1, 31)) : int'($urandom_range(32, 40));
      b1   = ($urandom % 12 == 0) ? 1'b0 : 1'b1;
      case ($urandom % 10)
        0:             op = 2'b00;
        1:             op = 2'b11;
        2, 3, 4, 5:    op = 2'b01;
        default:       op = 2'b10;
      endcase
      case ($urandom % 4)
        0:       phy = 5'd0;
        1:       phy = 5'd1;
        2:       phy = 5'd7;
        default: phy = 5'($urandom);
      endcase
      ta   = ($urandom % 6 == 0) ? 2'($urandom) : 2'b10;
      drop = ($urandom % 8 == 0) ? int'($urandom_range(14, 31)) : -1;
      run_frame($sformatf("rnd%0d", t), pre, b1, op, phy, 5'($urandom), ta,
                16'($urandom), 16'($urandom), drop);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_peripheral_px.md
Name: mdio_peripheral_px

Overview:
- Parametrised successor to the single-address MDIO peripheral: a Clause-22 MDIO target that decodes complete frames (preamble, ST, OP, PHYAD, REGAD, TA, DATA) from the station-side MDIO_OUT/MDIO_OE pair.
- Filters on its own PHY address, with optional broadcast writes, and validates ST/OP/TA.
- Bounds register access to NUM_REGS and reports malformed or aborted frames.
- Sits between the MDIO controller and a register bank: presents ADDR/WR_DATA/WR_STB/RD_STB and returns read data serially on MDIO_IN with a drive enable.

Parameters:
- PHY_ADDR, 5'd1, PHY address this target answers to.
- PRE_LEN, 32, minimum consecutive preamble 1s required before ST; legal range 1..32.
- BCAST_EN, 1, accept PHYAD 0 for writes only; reads to PHYAD 0 are ignored.
- CHECK_TA, 1, on writes, require TA = 10; mismatch aborts the frame.
- NUM_REGS, 32, REGAD >= NUM_REGS is out of range: no strobes, and reads return 16'h0000.

Ports:
- MDC  in  1  MDIO clock; every register updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- MDIO_OE  in  1  station drives the bus.
- MDIO_OUT  in  1  serial bit from station.
- RD_DATA  in  16  register read data; sampled once per read frame.
- ADDR  out  5  register address.
- WR_DATA  out  16  write data.
- WR_STB  out  1  one-cycle write strobe.
- RD_STB  out  1  one-cycle read request.
- MDIO_IN  out  1  serial bit to station.
- MDIO_IN_EN  out  1  target drives MDIO_IN.
- MDIO_DONE  out  1  one-cycle end-of-frame pulse.
- MDIO_ERR  out  1  one-cycle malformed/aborted-frame pulse.

Behaviour:
- Reset: at the first posedge with RESET=1, all outputs go to 0, state goes to IDLE and the preamble count to 0. Reset mid-frame discards the frame with no strobes, and the next frame needs a full preamble.
- Frame bit numbering: frame bits b0..b31 follow the preamble (b0-b1 ST, b2-b3 OP, b4-b8 PHYAD, b9-b13 REGAD, b14-b15 TA, b16-b31 DATA). e(k) is the posedge that samples bk. All fields are MSB first.
- IDLE: the preamble count increments (saturating at PRE_LEN) when MDIO_OE=1 and MDIO_OUT=1. It clears when MDIO_OE=0, or when MDIO_OUT=0 with count < PRE_LEN. MDIO_OUT=0 with count >= PRE_LEN is b0 and enters ST.
- ST: b1 must be 1. Otherwise MDIO_ERR pulses and the block returns to IDLE.
- OP: 10 = read, 01 = write. 00/11 pulse MDIO_ERR and return to IDLE.
- PHYAD then REGAD are shifted in.
- At e(13), the frame is selected if PHYAD == PHY_ADDR, or if PHYAD == 0 with BCAST_EN=1 and OP = write.
  - Unselected frame: go to SKIP, count the remaining 18 edges, return to IDLE. No outputs toggle.
  - Selected frame: ADDR <= REGAD at e(13).
- Write-phase MDIO_OE: for writes, MDIO_OE must stay 1 through b31. For reads, it must stay 1 through b13 and is ignored from b14 on. A violation pulses MDIO_ERR and returns to IDLE with no WR_STB.
- Read timing:
  - RD_STB=1 for the cycle after e(13), only if REGAD < NUM_REGS.
  - e(14): the shift register loads RD_DATA (or 0 if out of range); MDIO_IN_EN <= 1, MDIO_IN <= 0.
  - e(15)..e(30): MDIO_IN <= data[15]..data[0].
  - e(31): MDIO_IN_EN <= 0, MDIO_IN <= 0, MDIO_DONE pulses, state goes to IDLE.
- Write timing:
  - e(14)/e(15): if CHECK_TA=1 and TA != 10, MDIO_ERR pulses and the block returns to IDLE.
  - e(16)..e(31) shift in the data.
  - e(31): WR_DATA is updated and then held; WR_STB pulses only if REGAD < NUM_REGS; MDIO_DONE pulses.
- Back-to-back frames: after e(31) the next frame needs a fresh preamble, and the count starts at 0.
- ERR and DONE never assert in the same cycle. All strobes are exactly one MDC cycle wide.

Decomposition:
- Shared package mdio_pkg:
  - state enum (IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP)
  - OP_READ = 2'b10, OP_WRITE = 2'b01
  - TA_WRITE = 2'b10
  - field lengths
  - MDIO_DATA_W = 16
- One sub-module, mdio_preamble_det: the saturating preamble counter with start detect, parametrised by PRE_LEN.

Test Plan:
- Default parameters: 32×1, ST 01, OP 01, PHYAD 1, REGAD 5, TA 10, data 16'hA5C3 -> ADDR=5, WR_DATA=16'hA5C3, WR_STB and MDIO_DONE each high one cycle after e(31), MDIO_ERR=0.
- Read: PHYAD 1, REGAD 3, RD_DATA=16'h1234 -> RD_STB one cycle after e(13); MDIO_IN_EN high e(14)..e(30); MDIO_IN = 0 then 0001_0010_0011_0100 serially; MDIO_DONE at e(31).
- PHYAD 7 write, then PHYAD 0 write with BCAST_EN=1 -> no activity for the first frame; WR_STB for the second. PHYAD 0 read -> no RD_STB, MDIO_IN_EN stays 0.
- Only 20 preamble bits with PRE_LEN=32 -> frame ignored. OP 11 after a valid preamble -> MDIO_ERR pulse, no strobes.
- Write with MDIO_OE dropped at b20, and a separate write with TA=11 -> MDIO_ERR pulse, no WR_STB. An immediately following valid frame completes normally.
- RESET asserted at b10 of a read -> all outputs 0 at the next edge. REGAD 31 with NUM_REGS=16 -> read returns 16'h0000 with no RD_STB.
